// File: rtl/decoder_pkg.sv
// Shared types and constants for the registered one-hot decoder.
package decoder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_e;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  localparam int MAX_OUT_W = 256;

  // Full-width idle pattern; callers slice the low out_w bits.
  function automatic logic [MAX_OUT_W-1:0] idle_word(input int out_w, input logic active_low);
    logic [MAX_OUT_W-1:0] w;
    w = '0;
    for (int i = 0; i < MAX_OUT_W; i++) begin
      if (i < out_w) w[i] = active_low;
    end
    return w;
  endfunction

endpackage

// File: rtl/onehot_dec.sv
// Pure combinational binary-to-one-hot decoder, bit 0 is the LSB.
module onehot_dec #(
  parameter int SEL_W = 3
) (
  input  logic [SEL_W-1:0]      sel,
  output logic [(2**SEL_W)-1:0] dec
);

  always_comb begin
    dec      = '0;
    dec[sel] = 1'b1;
  end

endmodule

// File: rtl/decoder_seq.sv
// Registered one-hot decoder with a handshake-driven DIRECT mode and a
// step-driven SCAN mode; outputs park at the idle word when not valid.
//
//   state  | meaning
//   IDLE   | disabled, outputs at idle word, index 0
//   DIRECT | index loaded from data_in on each valid/ready transfer
//   SCAN   | index walks 0..OUT_W-1 on step, wrap pulses after rollover
module decoder_seq
  import decoder_pkg::*;
#(
  parameter int   SEL_W      = 3,
  parameter bit   ACTIVE_LOW = 1'b0,
  localparam int  OUT_W      = 2**SEL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SEL_W-1:0] data_in,
  input  logic             step,
  output logic [OUT_W-1:0] data_out,
  output logic             out_valid,
  output logic [SEL_W-1:0] index,
  output logic             wrap
);

  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_DIRECT = DIRECT;
  localparam logic [1:0] ST_SCAN   = SCAN;

  localparam logic [MAX_OUT_W-1:0] IDLE_FULL = idle_word(OUT_W, ACTIVE_LOW);
  localparam logic [OUT_W-1:0]     IDLE_WORD = IDLE_FULL[OUT_W-1:0];
  localparam logic [SEL_W-1:0]     LAST_IDX  = {SEL_W{1'b1}};

  logic [1:0]       state, state_nxt;
  logic [SEL_W-1:0] index_nxt;
  logic             valid_nxt;
  logic             wrap_nxt;
  logic [OUT_W-1:0] dec;
  logic [OUT_W-1:0] data_nxt;

  assign in_ready = en && (mode == MODE_DIRECT);

  // A mode change always takes priority; the strobe of that cycle is dropped.
  always_comb begin
    state_nxt = state;
    index_nxt = index;
    valid_nxt = out_valid;
    wrap_nxt  = 1'b0;
    if (!en) begin
      state_nxt = ST_IDLE;
      index_nxt = '0;
      valid_nxt = 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DIRECT: begin
          if (mode == MODE_SCAN) begin
            state_nxt = ST_SCAN;
            index_nxt = '0;
            valid_nxt = 1'b1;
          end else if (state == ST_IDLE) begin
            state_nxt = ST_DIRECT;
            index_nxt = '0;
            valid_nxt = 1'b0;
          end else if (in_valid) begin
            index_nxt = data_in;
            valid_nxt = 1'b1;
          end
        end
        ST_SCAN: begin
          if (mode == MODE_DIRECT) begin
            state_nxt = ST_DIRECT;
            index_nxt = '0;
            valid_nxt = 1'b0;
          end else if (step) begin
            index_nxt = index + 1'b1;
            wrap_nxt  = (index == LAST_IDX);
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          index_nxt = '0;
          valid_nxt = 1'b0;
        end
      endcase
    end
  end

  onehot_dec #(.SEL_W(SEL_W)) u_dec (
    .sel (index_nxt),
    .dec (dec)
  );

  assign data_nxt = valid_nxt ? (dec ^ {OUT_W{ACTIVE_LOW}}) : IDLE_WORD;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      index     <= '0;
      out_valid <= 1'b0;
      wrap      <= 1'b0;
      data_out  <= IDLE_WORD;
    end else begin
      state     <= state_nxt;
      index     <= index_nxt;
      out_valid <= valid_nxt;
      wrap      <= wrap_nxt;
      data_out  <= data_nxt;
    end
  end

endmodule

// File: tb/tb_decoder_seq.sv
// Directed bench for decoder_seq: SEL_W=3 in both polarities plus SEL_W=1/5 sweeps.
module tb_decoder_seq;

  logic clk;
  logic rst_n;
  logic en;
  logic mode;
  logic in_valid;
  logic step;
  logic [2:0] d3;
  logic [0:0] d1;
  logic [4:0] d5;

  logic       rdy_m, val_m, wrap_m;
  logic [7:0] out_m;
  logic [2:0] idx_m;
  logic       rdy_l, val_l, wrap_l;
  logic [7:0] out_l;
  logic [2:0] idx_l;
  logic       rdy_1, val_1, wrap_1;
  logic [1:0] out_1;
  logic [0:0] idx_1;
  logic        rdy_5, val_5, wrap_5;
  logic [31:0] out_5;
  logic [4:0]  idx_5;

  int vecs;
  int errs;

  decoder_seq #(.SEL_W(3), .ACTIVE_LOW(1'b0)) u_main (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .in_valid(in_valid),
    .in_ready(rdy_m), .data_in(d3), .step(step), .data_out(out_m),
    .out_valid(val_m), .index(idx_m), .wrap(wrap_m));

  decoder_seq #(.SEL_W(3), .ACTIVE_LOW(1'b1)) u_low (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .in_valid(in_valid),
    .in_ready(rdy_l), .data_in(d3), .step(step), .data_out(out_l),
    .out_valid(val_l), .index(idx_l), .wrap(wrap_l));

  decoder_seq #(.SEL_W(1), .ACTIVE_LOW(1'b0)) u_w1 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .in_valid(in_valid),
    .in_ready(rdy_1), .data_in(d1), .step(step), .data_out(out_1),
    .out_valid(val_1), .index(idx_1), .wrap(wrap_1));

  decoder_seq #(.SEL_W(5), .ACTIVE_LOW(1'b0)) u_w5 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .in_valid(in_valid),
    .in_ready(rdy_5), .data_in(d5), .step(step), .data_out(out_5),
    .out_valid(val_5), .index(idx_5), .wrap(wrap_5));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick();
    vecs++; if (out_m !== 8'h00) begin errs++; $display("FAIL rst_data got=%h exp=%h", out_m, 8'h00); end
    vecs++; if (out_l !== 8'hFF) begin errs++; $display("FAIL rst_data_low got=%h exp=%h", out_l, 8'hFF); end
    vecs++; if (val_m !== 1'b0) begin errs++; $display("FAIL rst_valid got=%b exp=0", val_m); end
    vecs++; if (idx_m !== 3'd0) begin errs++; $display("FAIL rst_index got=%0d exp=0", idx_m); end
    vecs++; if (wrap_m !== 1'b0) begin errs++; $display("FAIL rst_wrap got=%b exp=0", wrap_m); end
    vecs++; if (rdy_m !== 1'b0) begin errs++; $display("FAIL rst_ready got=%b exp=0", rdy_m); end
    rst_n = 1'b1;
    tick();
    en = 1'b1; mode = 1'b1;
    tick();
    step = 1'b1;
    tick();
    tick();
    step = 1'b0;
    vecs++; if (out_m !== 8'h04) begin errs++; $display("FAIL pre_rst_scan got=%h exp=%h", out_m, 8'h04); end
    #2 rst_n = 1'b0;
    #1;
    vecs++; if (out_m !== 8'h00) begin errs++; $display("FAIL async_rst_data got=%h exp=%h", out_m, 8'h00); end
    vecs++; if (out_l !== 8'hFF) begin errs++; $display("FAIL async_rst_low got=%h exp=%h", out_l, 8'hFF); end
    vecs++; if (val_m !== 1'b0) begin errs++; $display("FAIL async_rst_valid got=%b exp=0", val_m); end
    vecs++; if (idx_m !== 3'd0) begin errs++; $display("FAIL async_rst_index got=%0d exp=0", idx_m); end
    en = 1'b0; mode = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_direct();
    en = 1'b1; mode = 1'b0; in_valid = 1'b0;
    tick();
    vecs++; if (val_m !== 1'b0 || out_m !== 8'h00) begin errs++; $display("FAIL direct_entry got=%b/%h exp=0/00", val_m, out_m); end
    vecs++; if (rdy_m !== 1'b1) begin errs++; $display("FAIL direct_ready got=%b exp=1", rdy_m); end
    in_valid = 1'b1; d3 = 3'd5;
    tick();
    vecs++; if (out_m !== 8'h20 || idx_m !== 3'd5 || val_m !== 1'b1) begin errs++; $display("FAIL direct_5 got=%h/%0d/%b exp=20/5/1", out_m, idx_m, val_m); end
    vecs++; if (out_l !== 8'hDF) begin errs++; $display("FAIL direct_5_low got=%h exp=%h", out_l, 8'hDF); end
    d3 = 3'd2;
    tick();
    vecs++; if (out_m !== 8'h04 || idx_m !== 3'd2) begin errs++; $display("FAIL direct_2 got=%h/%0d exp=04/2", out_m, idx_m); end
    in_valid = 1'b0; d3 = 3'd7; step = 1'b1;
    tick();
    step = 1'b0;
    vecs++; if (out_m !== 8'h04 || idx_m !== 3'd2 || val_m !== 1'b1) begin errs++; $display("FAIL direct_hold got=%h/%0d/%b exp=04/2/1", out_m, idx_m, val_m); end
    vecs++; if (out_l !== 8'hFB) begin errs++; $display("FAIL direct_hold_low got=%h exp=%h", out_l, 8'hFB); end
  endtask

  task automatic test_scan_wrap();
    logic [7:0] exp;
    int wraps;
    mode = 1'b1;
    #1;
    vecs++; if (rdy_m !== 1'b0) begin errs++; $display("FAIL scan_ready got=%b exp=0", rdy_m); end
    tick();
    vecs++; if (out_m !== 8'h01 || idx_m !== 3'd0 || val_m !== 1'b1) begin errs++; $display("FAIL scan_entry got=%h/%0d/%b exp=01/0/1", out_m, idx_m, val_m); end
    step = 1'b1;
    wraps = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      exp = 8'h01 << (i % 8);
      if (wrap_m === 1'b1) wraps++;
      vecs++; if (out_m !== exp) begin errs++; $display("FAIL scan_step%0d got=%h exp=%h", i, out_m, exp); end
      vecs++; if (wrap_m !== (i == 8)) begin errs++; $display("FAIL scan_wrap%0d got=%b exp=%b", i, wrap_m, (i == 8)); end
    end
    step = 1'b0;
    tick();
    vecs++; if (out_m !== 8'h01 || wrap_m !== 1'b0) begin errs++; $display("FAIL scan_after_wrap got=%h/%b exp=01/0", out_m, wrap_m); end
    vecs++; if (wraps != 1) begin errs++; $display("FAIL scan_wrap_count got=%0d exp=1", wraps); end
  endtask

  task automatic test_mode_switch();
    step = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    step = 1'b0;
    vecs++; if (idx_m !== 3'd6 || out_m !== 8'h40) begin errs++; $display("FAIL switch_pre got=%0d/%h exp=6/40", idx_m, out_m); end
    mode = 1'b0; step = 1'b1; in_valid = 1'b1; d3 = 3'd5;
    tick();
    step = 1'b0; in_valid = 1'b0;
    vecs++; if (val_m !== 1'b0 || out_m !== 8'h00) begin errs++; $display("FAIL switch_to_direct got=%b/%h exp=0/00", val_m, out_m); end
    in_valid = 1'b1; d3 = 3'd3;
    tick();
    vecs++; if (out_m !== 8'h08 || idx_m !== 3'd3 || val_m !== 1'b1) begin errs++; $display("FAIL switch_xfer3 got=%h/%0d/%b exp=08/3/1", out_m, idx_m, val_m); end
    d3 = 3'd6; mode = 1'b1;
    tick();
    in_valid = 1'b0;
    vecs++; if (out_m !== 8'h01 || idx_m !== 3'd0) begin errs++; $display("FAIL switch_rescan got=%h/%0d exp=01/0", out_m, idx_m); end
  endtask

  task automatic test_enable_drop();
    mode = 1'b0; in_valid = 1'b1; d3 = 3'd4;
    tick();
    tick();
    vecs++; if (out_m !== 8'h10) begin errs++; $display("FAIL drop_setup got=%h exp=%h", out_m, 8'h10); end
    d3 = 3'd7; en = 1'b0;
    #1;
    vecs++; if (rdy_m !== 1'b0) begin errs++; $display("FAIL drop_ready got=%b exp=0", rdy_m); end
    tick();
    vecs++; if (out_m !== 8'h00 || val_m !== 1'b0 || idx_m !== 3'd0) begin errs++; $display("FAIL drop_idle got=%h/%b/%0d exp=00/0/0", out_m, val_m, idx_m); end
    vecs++; if (out_l !== 8'hFF) begin errs++; $display("FAIL drop_idle_low got=%h exp=%h", out_l, 8'hFF); end
    in_valid = 1'b0;
  endtask

  task automatic test_sweep();
    logic [31:0] e5;
    logic [1:0]  e1;
    en = 1'b1; mode = 1'b0; in_valid = 1'b0;
    tick();
    in_valid = 1'b1;
    for (int i = 0; i < 32; i++) begin
      d5 = i[4:0]; d1 = i[0:0]; d3 = i[2:0];
      tick();
      e5 = 32'h1 << i;
      e1 = 2'h1 << (i % 2);
      vecs++; if (out_5 !== e5 || idx_5 !== i[4:0] || !$onehot(out_5)) begin errs++; $display("FAIL sweep5_direct%0d got=%h/%0d exp=%h/%0d", i, out_5, idx_5, e5, i); end
      vecs++; if (out_1 !== e1 || idx_1 !== i[0:0] || val_1 !== 1'b1) begin errs++; $display("FAIL sweep1_direct%0d got=%h/%0d exp=%h/%0d", i, out_1, idx_1, e1, i % 2); end
    end
    in_valid = 1'b0; mode = 1'b1;
    tick();
    vecs++; if (out_5 !== 32'h1 || out_1 !== 2'h1) begin errs++; $display("FAIL sweep_scan_entry got=%h/%h exp=1/1", out_5, out_1); end
    step = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      tick();
      e5 = 32'h1 << (k % 32);
      e1 = 2'h1 << (k % 2);
      vecs++; if (out_5 !== e5 || idx_5 !== 5'(k % 32) || wrap_5 !== (k == 32)) begin errs++; $display("FAIL sweep5_scan%0d got=%h/%0d/%b exp=%h/%0d/%b", k, out_5, idx_5, wrap_5, e5, k % 32, (k == 32)); end
      vecs++; if (out_1 !== e1 || wrap_1 !== (k % 2 == 0) || !$onehot(out_1)) begin errs++; $display("FAIL sweep1_scan%0d got=%h/%b exp=%h/%b", k, out_1, wrap_1, e1, (k % 2 == 0)); end
    end
    step = 1'b0;
  endtask

  initial begin
    vecs = 0; errs = 0;
    rst_n = 1'b0; en = 1'b0; mode = 1'b0; in_valid = 1'b0; step = 1'b0;
    d3 = '0; d1 = '0; d5 = '0;
    test_reset();
    test_direct();
    test_scan_wrap();
    test_mode_switch();
    test_enable_drop();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
